// File: rtl/vga_mode_pkg.sv
// Shared definitions for the VGA mode sequencer.
// Holds the display mode encodings, the sequencer FSM states, the packed
// configuration record (mode plus the two multipliers) and the helper
// that turns a multiplier pair into the normalising divisor.
// Build option: VGA_MODE_AUTOCYCLE_EN (used by vga_mode_sequencer) adds the
// automatic mode stepping feature; nothing in this package depends on it.
package vga_mode_pkg;

    localparam int CFG_W                = 8;
    localparam int DEBOUNCE_CYC_DEFAULT = 250000;

    typedef enum logic [1:0] {
        MODE_PASS        = 2'd0,
        MODE_FOUR_COLOUR = 2'd1,
        MODE_DIM_QUAD    = 2'd2,
        MODE_DOMINANT    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    typedef struct packed {
        mode_t      mode;
        logic [2:0] mul1;
        logic [2:0] mul2;
    } cfg_t;

    // The sum of two 3-bit multipliers always fits in 4 bits; a zero sum
    // would make the datapath divide by zero, so it is replaced by 1.
    function automatic logic [3:0] calcDiv(input logic [2:0] mul1, input logic [2:0] mul2);
        logic [3:0] sum;
        sum = {1'b0, mul1} + {1'b0, mul2};
        return (sum == 4'd0) ? 4'd1 : sum;
    endfunction

endpackage

// File: rtl/vga_mode_sequencer_sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by a shared debounce counter
// for a W-bit switch bus.
// Ports:
//   iCLK        clock
//   iRST_N      asynchronous active-low reset
//   iIn         raw asynchronous input bus
//   oStable     last value that stayed unchanged for DEBOUNCE_CYC cycles
//   oNewStable  one-cycle strobe, high in the cycle oStable is (re)loaded
module sw_debounce
    import vga_mode_pkg::*;
#(
    parameter int W            = 10,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int CNT_W        = 18
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic [W-1:0] iIn,
    output logic [W-1:0] oStable,
    output logic         oNewStable
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYC - 2);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     prev;
    logic [CNT_W-1:0] count;

    // Any bit change restarts the count for the whole bus. The counter
    // saturates, so a held value is only captured once: the strobe fires
    // on the step that takes the counter to its maximum.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            count      <= '0;
            oStable    <= '0;
            oNewStable <= 1'b0;
        end else begin
            sync1      <= iIn;
            sync2      <= sync1;
            prev       <= sync2;
            oNewStable <= 1'b0;
            if (sync2 != prev) begin
                count <= '0;
            end else if (count != CNT_MAX) begin
                count <= count + CNT_W'(1);
                if (count == CNT_PRE) begin
                    oStable    <= sync2;
                    oNewStable <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_mode_sequencer.sv
// vga_mode_sequencer: owns the colour-effect configuration of the VGA
// datapath. Debounced switch changes are held pending and only made active
// on a frame boundary (falling edge of vertical sync) so a frame is never
// drawn in two modes.
// Build option: VGA_MODE_AUTOCYCLE_EN - when defined, stable SW[9]=1 makes
// the mode step 0->1->2->3->0 every AUTO_FRAMES frames instead of following
// SW[7:6]. Undefined (default), SW[9] is ignored.
// Ports:
//   iCLK        pixel clock
//   iRST_N      asynchronous active-low reset
//   iSW         raw board switches (SW[7:6] mode, SW[2:0] mul1, SW[5:3] mul2,
//               SW[8] freeze, SW[9] auto-cycle)
//   iVGA_VS     vertical sync, active low, synchronous to iCLK
//   oMode       active display mode
//   oMul1/oMul2 active multipliers
//   oDiv        normalising divisor (oMul1+oMul2, 1 when zero)
//   oPending    a debounced change is waiting for a frame boundary
//   oUpdate     one-cycle pulse when a new configuration becomes active
//   oFrame_Cnt  frame boundaries since reset, wrapping
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int CNT_W        = 18
`ifdef VGA_MODE_AUTOCYCLE_EN
    ,
    parameter int AUTO_FRAMES  = 120
`endif
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [9:0]  iSW,
    input  logic        iVGA_VS,
    output logic [1:0]  oMode,
    output logic [2:0]  oMul1,
    output logic [2:0]  oMul2,
    output logic [3:0]  oDiv,
    output logic        oPending,
    output logic        oUpdate,
    output logic [15:0] oFrame_Cnt
);

    logic [9:0]       swStable;
    logic             swNewStable;
    logic             freeze;
    logic             autoOn;
    logic             autoStep;
    logic             autoPulse;
    cfg_t             candidate;
    cfg_t             activeCfg;
    cfg_t             pendingCfg;
    logic [CFG_W-1:0] candidateBits;
    logic [CFG_W-1:0] activeBits;
    logic             vsReg;
    logic             boundary;
    logic [3:0]       divReg;
    logic [15:0]      frameCnt;
    logic             latchPending;
    logic             doApply;
    state_t           state;
    state_t           nextState;

    sw_debounce #(
        .W            (10),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W)
    ) uDebounce (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iIn        (iSW),
        .oStable    (swStable),
        .oNewStable (swNewStable)
    );

    assign freeze   = swStable[8];
    assign boundary = vsReg & ~iVGA_VS;

`ifdef VGA_MODE_AUTOCYCLE_EN
    logic [15:0] stepCnt;

    assign autoOn   = swStable[9];
    assign autoStep = autoOn && !freeze && boundary && (stepCnt == 16'(AUTO_FRAMES - 1));

    // Counts boundaries while auto-cycling; dropping SW[9] or freezing
    // restarts the count so the next step is a full AUTO_FRAMES away.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            stepCnt   <= '0;
            autoPulse <= 1'b0;
        end else begin
            autoPulse <= autoStep;
            if (!autoOn || freeze) begin
                stepCnt <= '0;
            end else if (boundary) begin
                stepCnt <= autoStep ? 16'd0 : stepCnt + 16'd1;
            end
        end
    end
`else
    logic unusedSw9;

    assign unusedSw9 = swStable[9];
    assign autoOn    = 1'b0;
    assign autoStep  = 1'b0;
    assign autoPulse = 1'b0;
`endif

    // While auto-cycling owns the mode, the candidate mirrors the active
    // mode so the mode switches alone never raise a pending change.
    always_comb begin
        candidate      = '0;
        candidate.mode = autoOn ? activeCfg.mode : mode_t'(swStable[7:6]);
        candidate.mul1 = swStable[2:0];
        candidate.mul2 = swStable[5:3];
    end

    assign candidateBits = candidate;
    assign activeBits    = activeCfg;

    // A fresh stable value always wins over a boundary in the same cycle,
    // so a change that settles exactly on a boundary waits for the next one.
    always_comb begin
        nextState    = state;
        latchPending = 1'b0;
        doApply      = 1'b0;
        case (state)
            IDLE: begin
                if (candidateBits != activeBits) begin
                    nextState    = PENDING;
                    latchPending = 1'b1;
                end
            end
            PENDING: begin
                if (swNewStable) begin
                    latchPending = 1'b1;
                    if (candidateBits == activeBits) begin
                        nextState = IDLE;
                    end
                end else if (boundary && !freeze) begin
                    nextState = APPLY;
                    doApply   = 1'b1;
                end
            end
            APPLY:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register, frame boundary detection and the pending holding register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            vsReg      <= 1'b0;
            frameCnt   <= '0;
            pendingCfg <= '0;
        end else begin
            state <= nextState;
            vsReg <= iVGA_VS;
            if (boundary) begin
                frameCnt <= frameCnt + 16'd1;
            end
            if (latchPending) begin
                pendingCfg <= candidate;
            end
        end
    end

    // The active configuration changes on the edge that leaves PENDING, so
    // it is visible together with the APPLY-state update pulse. An auto
    // step overrides the mode field of anything applied in the same cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            activeCfg <= '0;
            divReg    <= 4'd1;
        end else begin
            if (doApply) begin
                activeCfg <= pendingCfg;
                divReg    <= calcDiv(pendingCfg.mul1, pendingCfg.mul2);
            end
            if (autoOn) begin
                activeCfg.mode <= autoStep ? mode_t'(activeCfg.mode + 2'd1) : activeCfg.mode;
            end
        end
    end

    assign oMode      = activeCfg.mode;
    assign oMul1      = activeCfg.mul1;
    assign oMul2      = activeCfg.mul2;
    assign oDiv       = divReg;
    assign oPending   = (state == PENDING);
    assign oUpdate    = (state == APPLY) || autoPulse;
    assign oFrame_Cnt = frameCnt;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer with DEBOUNCE_CYC=8 and a
// 200-cycle vertical sync period. Expected configurations are queued when a
// switch change is driven and compared whenever the DUT pulses oUpdate.
module tb_vga_mode_sequencer;

    logic        iCLK;
    logic        iRST_N;
    logic [9:0]  iSW;
    logic        iVGA_VS;
    logic [1:0]  oMode;
    logic [2:0]  oMul1;
    logic [2:0]  oMul2;
    logic [3:0]  oDiv;
    logic        oPending;
    logic        oUpdate;
    logic [15:0] oFrame_Cnt;

    int          errCount = 0;
    int          checkCount = 0;
    int          cyc = 0;
    int          phase = 0;
    int          lastFallCyc = 0;
    int          expFrames = 0;
    int          updCount = 0;
    logic [11:0] expQ[$];

    vga_mode_sequencer #(
        .DEBOUNCE_CYC (8),
        .CNT_W        (4)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iSW        (iSW),
        .iVGA_VS    (iVGA_VS),
        .oMode      (oMode),
        .oMul1      (oMul1),
        .oMul2      (oMul2),
        .oDiv       (oDiv),
        .oPending   (oPending),
        .oUpdate    (oUpdate),
        .oFrame_Cnt (oFrame_Cnt)
    );

    // Free-running clock.
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Cycle counter used to measure apply latency against the VS fall.
    always @(posedge iCLK) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] sw);
        iSW = sw;
    endtask

    // Expected {mode, mul1, mul2, div} for a switch word; div worked out here.
    function automatic logic [11:0] expCfg(input logic [9:0] sw);
        int sum;
        sum = int'(sw[2:0]) + int'(sw[5:3]);
        if (sum == 0) sum = 1;
        return {sw[7:6], sw[2:0], sw[5:3], 4'(sum)};
    endfunction

    task automatic waitPhase(input int p);
        int n;
        n = 0;
        do begin
            @(negedge iCLK);
            n++;
        end while (phase != p && n < 400);
        if (phase != p) checkOutput("phaseTimeout", phase, p);
    endtask

    task automatic waitUpdate(input string tag, input int limit);
        int start;
        int n;
        start = updCount;
        n = 0;
        while (updCount == start && n < limit) begin
            @(negedge iCLK);
            n++;
        end
        checkOutput(tag, updCount - start, 1);
    endtask

    // VS generator: low for 4 cycles at the start of every 200-cycle frame.
    // Keeps its own frame model and checks it mid-frame, away from the fall.
    initial begin
        iVGA_VS = 1'b1;
        forever begin
            @(posedge iCLK);
            #1;
            phase = (phase == 199) ? 0 : phase + 1;
            if (phase == 0) begin
                iVGA_VS = 1'b0;
                lastFallCyc = cyc;
                if (iRST_N) expFrames++;
            end else if (phase == 4) begin
                iVGA_VS = 1'b1;
            end
            if (!iRST_N) expFrames = 0;
            if (phase == 100 && iRST_N) checkOutput("frameCnt", oFrame_Cnt, expFrames);
        end
    end

    // Scoreboard side: every update pulse must match the oldest queued config.
    always @(negedge iCLK) begin
        if (iRST_N && oUpdate) begin
            updCount++;
            if (expQ.size() == 0) begin
                checkOutput("spuriousUpdate", 1, 0);
            end else begin
                checkOutput("applyCfg", {oMode, oMul1, oMul2, oDiv}, expQ.pop_front());
                checkOutput("applyPending", oPending, 0);
                checkOutput("applyLatency", cyc - lastFallCyc, 1);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] sw;
        int         pendHigh;
        int         updBefore;

        // Reset values.
        iRST_N = 1'b0;
        applyStimulus(10'd0);
        repeat (10) @(negedge iCLK);
        checkOutput("rstMode", oMode, 0);
        checkOutput("rstMul1", oMul1, 0);
        checkOutput("rstMul2", oMul2, 0);
        checkOutput("rstDiv", oDiv, 1);
        checkOutput("rstPending", oPending, 0);
        checkOutput("rstUpdate", oUpdate, 0);
        checkOutput("rstFrame", oFrame_Cnt, 0);
        iRST_N = 1'b1;

        // Idle frames with SW=0: only the frame counter moves.
        repeat (3) waitPhase(150);
        checkOutput("idleNoUpdate", updCount, 0);
        checkOutput("idlePending", oPending, 0);

        // Mid-frame change, applied one cycle after the next VS fall.
        waitPhase(50);
        sw = 10'b00_11_010_001;
        expQ.push_back(expCfg(sw));
        applyStimulus(sw);
        repeat (8) @(negedge iCLK);
        checkOutput("pendingEarly", oPending, 0);
        repeat (6) @(negedge iCLK);
        checkOutput("pendingSet", oPending, 1);
        checkOutput("pendingHoldMode", oMode, 0);
        waitUpdate("modeApply", 250);
        @(negedge iCLK);
        checkOutput("afterApplyPending", oPending, 0);
        checkOutput("afterApplyUpdate", oUpdate, 0);

        // Bouncing SW[2:0] never settles, then returns to the active value.
        updBefore = updCount;
        pendHigh = 0;
        for (int i = 0; i < 100; i++) begin
            sw[2:0] = (i % 2 == 0) ? 3'b110 : 3'b001;
            applyStimulus(sw);
            @(negedge iCLK);
            if (oPending) pendHigh++;
        end
        sw[2:0] = 3'b001;
        applyStimulus(sw);
        repeat (20) @(negedge iCLK);
        if (oPending) pendHigh++;
        checkOutput("bouncePending", pendHigh, 0);
        checkOutput("bounceUpdate", updCount - updBefore, 0);

        // Freeze holds a pending change across three boundaries.
        waitPhase(50);
        sw = 10'b0_1_10_011_100;
        applyStimulus(sw);
        repeat (14) @(negedge iCLK);
        checkOutput("freezePending", oPending, 1);
        updBefore = updCount;
        repeat (3) waitPhase(50);
        checkOutput("freezeNoApply", updCount - updBefore, 0);
        checkOutput("freezeStillPending", oPending, 1);
        checkOutput("freezeModeHeld", oMode, 3);
        sw[8] = 1'b0;
        expQ.push_back(expCfg(sw));
        applyStimulus(sw);
        waitUpdate("freezeRelease", 200);

        // Divisor corner cases: zero sum forced to 1, maximum sum 14.
        waitPhase(50);
        sw = 10'b0_0_01_000_000;
        expQ.push_back(expCfg(sw));
        applyStimulus(sw);
        waitUpdate("divZero", 200);
        checkOutput("divZeroVal", oDiv, 1);
        waitPhase(50);
        sw = 10'b0_0_00_111_111;
        expQ.push_back(expCfg(sw));
        applyStimulus(sw);
        waitUpdate("divMax", 200);
        checkOutput("divMaxVal", oDiv, 14);

        // Reset while a change is pending discards it.
        waitPhase(50);
        applyStimulus(10'b0_0_11_101_010);
        repeat (14) @(negedge iCLK);
        checkOutput("rstPendingSet", oPending, 1);
        iRST_N = 1'b0;
        #1;
        checkOutput("midRstMode", oMode, 0);
        checkOutput("midRstMul1", oMul1, 0);
        checkOutput("midRstMul2", oMul2, 0);
        checkOutput("midRstDiv", oDiv, 1);
        checkOutput("midRstPending", oPending, 0);
        checkOutput("midRstFrame", oFrame_Cnt, 0);
        repeat (3) @(negedge iCLK);
        applyStimulus(10'd0);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        updBefore = updCount;
        repeat (2) waitPhase(150);
        checkOutput("postRstNoApply", updCount - updBefore, 0);
        checkOutput("postRstMode", oMode, 0);
        checkOutput("postRstDiv", oDiv, 1);
        checkOutput("postRstPending", oPending, 0);

        checkOutput("queueEmpty", expQ.size(), 0);
        checkOutput("updateTotal", updCount, 4);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vga_mode_sequencer.md
Name: vga_mode_sequencer

Overview:
Owns the configuration of the VGA colour-effect datapath: display mode, the two weighting multipliers and the normalising divisor. Synchronises and debounces the board switches and holds any change pending. Applies the change only at a frame boundary (falling edge of VGA vertical sync), so the pixel datapath never switches mode mid-frame. Sits between the switch inputs and the VGA controller, in the pixel-clock domain.

Parameters:
DEBOUNCE_CYC, 250000, number of consecutive stable cycles before a switch value is accepted (10 ms at 25 MHz)
CNT_W, 18, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYC
AUTO_FRAMES, 120, frames per mode step in auto-cycle (optional feature only)

Ports:
iCLK  input  1  pixel clock
iRST_N  input  1  asynchronous active-low reset
iSW  input  10  raw board switches, asynchronous
iVGA_VS  input  1  vertical sync from the VGA controller, synchronous to iCLK, active low
oMode  output  2  active mode: 0 PASS, 1 FOUR_COLOUR, 2 DIM_QUAD, 3 DOMINANT
oMul1  output  3  active multiplier 1 (from SW[2:0])
oMul2  output  3  active multiplier 2 (from SW[5:3])
oDiv  output  4  normalising divisor, oMul1+oMul2, forced to 1 when the sum is 0
oPending  output  1  a debounced change is waiting for a frame boundary
oUpdate  output  1  one-cycle pulse in the cycle the new configuration becomes active
oFrame_Cnt  output  16  count of frame boundaries since reset, wraps at 65535->0

Behaviour:
- Interface: one clock, iCLK; reset iRST_N is asynchronous and active-low.
- Reset values: oMode=0, oMul1=0, oMul2=0, oDiv=1, oPending=0, oUpdate=0, oFrame_Cnt=0. All synchroniser, debounce and FSM state also clears.
- Synchroniser: iSW passes through 2 flops, reset value 0.
- Debounce: the counter clears whenever the synchronised value differs from the previous cycle. Otherwise it increments and saturates at DEBOUNCE_CYC-1. When it reaches DEBOUNCE_CYC-1, the value is "stable".
- Candidate config = {SW[7:6], SW[2:0], SW[5:3]} of the stable value. SW[8] is freeze. SW[9] is reserved for the optional feature.
- Frame boundary: iVGA_VS registered once; boundary = registered 1 and current 0. oFrame_Cnt increments at every boundary.
- FSM states: IDLE, PENDING, APPLY.
- IDLE -> PENDING: the stable candidate differs from the active config. The candidate is latched into a pending register and oPending=1.
- PENDING behaviour:
  - A newly stable candidate overwrites the pending register.
  - If the new stable candidate equals the active config, return to IDLE with oPending=0.
  - At a boundary with freeze=0, go to APPLY. With freeze=1, stay in PENDING.
- APPLY (exactly 1 cycle): active config <= pending. oDiv is computed from the new multipliers as a 4-bit sum. oUpdate=1 and oPending=0. Next state is IDLE.
- Latency: the outputs change on the clock edge that leaves PENDING. The new values and oUpdate are visible 1 cycle after the boundary cycle.
- Simultaneous events:
  - Candidate becomes stable in the same cycle as a boundary: the candidate is latched and applied at the next boundary, not the current one.
  - Boundary in the APPLY cycle: counted in oFrame_Cnt, causes no second apply.
- Freeze set while PENDING: the pending value is held. It is applied at the first boundary after freeze clears.
- Reset mid-PENDING: the pending value is discarded and outputs return to reset values.
- Bouncing input, i.e. a toggle every cycle: the counter never saturates, so no state change occurs.

Optional Feature:
VGA_MODE_AUTOCYCLE_EN
- Defined: when the stable SW[9]=1, SW[7:6] is ignored and oMode advances 0->1->2->3->0 every AUTO_FRAMES boundaries.
  - Each step updates at the boundary and pulses oUpdate.
  - Multipliers still come from the switches through the normal pending path.
  - The frame-step counter clears when SW[9] falls, when freeze is set, and at reset.
- Not defined: SW[9] is ignored, no step counter is built, and oMode follows only SW[7:6].

Decomposition:
- Package vga_mode_pkg:
  - mode encodings MODE_PASS=0, MODE_FOUR_COLOUR=1, MODE_DIM_QUAD=2, MODE_DOMINANT=3
  - FSM state encodings IDLE/PENDING/APPLY
  - the config record width (8 bits)
  - default DEBOUNCE_CYC
- Sub-module sw_debounce: 2-flop synchroniser plus debounce counter for a parameterised-width bus. Outputs the stable value and a one-cycle "new stable" strobe.

Test Plan:
All scenarios use DEBOUNCE_CYC=8 and a VS period of 200 cycles.
1. Reset, then SW=0 held -> all outputs at reset values, oFrame_Cnt increments once per VS falling edge, oUpdate never pulses.
2. SW set to 10'b00_11_010_001 mid-frame -> oPending=1 after 2+8 cycles. At the next VS fall +1 cycle: oMode=3, oMul1=1, oMul2=2, oDiv=3, a single oUpdate pulse, oPending=0.
3. SW[2:0] toggled every cycle for 100 cycles, then restored -> no oPending, no oUpdate.
4. SW[8]=1 with a mode change pending across 3 frames -> no apply. Clear SW[8] -> apply at the first following boundary.
5. oMul1=0 and oMul2=0 selected -> oDiv=1. oMul1=7 and oMul2=7 -> oDiv=14.
6. iRST_N pulsed low while oPending=1 -> immediate return to reset values. The pending config is never applied after reset is released.
